// File: rtl/mult_seq_if.sv
// rtl/mult_seq_if.sv - start/busy/done request bus for the iterative HI/LO multiplier
interface mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic             acc;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_op, acc, flush, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, acc, flush, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - WIDTH+1 cycle shift-add MULT/MULTU engine with registered HI/LO
// Define MULT_SEQ_MADD_EN to accumulate the product into HI/LO when acc is set.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  mult_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] pp_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             neg_q;
  logic             busy_q;
  logic             done_q;
`ifdef MULT_SEQ_MADD_EN
  logic             acc_q;
`endif

  logic [WIDTH-1:0]   abs_a_d;
  logic [WIDTH-1:0]   abs_b_d;
  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] result_d;

  // Magnitudes are W bits: the most negative operand maps to 2^(W-1) unchanged.
  always_comb begin
    abs_a_d = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b_d = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    sum_d   = {1'b0, pp_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    prod_d  = neg_q ? -{pp_q, mplier_q} : {pp_q, mplier_q};
`ifdef MULT_SEQ_MADD_EN
    result_d = acc_q ? ({hi_q, lo_q} + prod_d) : prod_d;
`else
    result_d = prod_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      pp_q     <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULT_SEQ_MADD_EN
      acc_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            mcand_q  <= abs_a_d;
            mplier_q <= abs_b_d;
            pp_q     <= '0;
            neg_q    <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            cnt_q    <= CW'(WIDTH);
`ifdef MULT_SEQ_MADD_EN
            acc_q    <= bus.acc;
`endif
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // The adder carry lands in the top bit of the partial product after the shift.
            pp_q     <= sum_d[WIDTH:1];
            mplier_q <= {sum_d[0], mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= FINISH;
            end
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (!bus.flush) begin
            {hi_q, lo_q} <= result_d;
            done_q       <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - directed scoreboard bench for mult_seq at WIDTH=32
module tb_mult_seq;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model = '0;

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] xa;
    logic [63:0] xb;
    xa = s ? {{32{a[31]}}, a} : {32'b0, a};
    xb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic ac, input bit push);
    logic [63:0] p;
    bus.a         = a;
    bus.b         = b;
    bus.signed_op = s;
    bus.acc       = ac;
    bus.start     = 1'b1;
    if (push) begin
      p = ref_mul(a, b, s);
`ifdef MULT_SEQ_MADD_EN
      if (ac) p = p + model;
`endif
      model = p;
      exp_q.push_back(p);
    end
  endtask

  task automatic wait_done(input string tag, input bit hold);
    int          cyc;
    int          busy_n;
    bit          seen;
    logic [63:0] expv;
    cyc    = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!hold) bus.start = 1'b0;
      else if (cyc == 10) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_n++;
    end
    check({tag, "_latency"}, 64'(cyc - 1), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check({tag, "_result"}, {bus.hi, bus.lo}, expv);
  endtask

  initial begin
    bit got_done;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.acc       = 1'b0;
    bus.flush     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(32'd3, 32'd5, 1'b0, 1'b0, 1'b1);                 wait_done("u3x5", 1'b0);
    launch(32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 1'b1);          wait_done("s_m1x2", 1'b0);
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);   wait_done("u_max", 1'b0);
    launch(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1);   wait_done("s_min", 1'b0);
    launch(32'd7, 32'd6, 1'b0, 1'b0, 1'b1);                 wait_done("u7x6", 1'b0);

    launch(32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    repeat (10) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_done", 64'(bus.done), 64'd0);
    check("flush_hold", {bus.hi, bus.lo}, 64'd42);
    got_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) got_done = 1'b1;
    end
    check("flush_no_done", 64'(got_done), 64'd0);
    check("flush_hold_late", {bus.hi, bus.lo}, model);
    launch(32'd2, 32'd2, 1'b0, 1'b0, 1'b1);                 wait_done("u2x2", 1'b0);

    bus.flush = 1'b1;
    launch(32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("idle_flush_start_busy", 64'(bus.busy), 64'd0);

    launch(32'd11, 32'd13, 1'b0, 1'b0, 1'b0);
    repeat (15) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_hi", 64'(bus.hi), 64'd0);
    check("midrst_lo", 64'(bus.lo), 64'd0);
    model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(32'hFFFFFFFD, 32'd7, 1'b1, 1'b0, 1'b1);          wait_done("after_rst", 1'b0);

    launch(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1);   wait_done("b2b0", 1'b1);
    launch(32'h80000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);   wait_done("b2b1", 1'b1);
    launch(32'hCAFEBABE, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);   wait_done("b2b2", 1'b1);
    bus.start = 1'b0;

    for (int i = 0; i < 4; i++) begin
      launch($urandom, $urandom, i[0], 1'b0, 1'b1);
      wait_done("rnd", 1'b0);
    end

    launch(32'h10, 32'h10, 1'b0, 1'b0, 1'b1);               wait_done("madd_base", 1'b0);
    launch(32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 1'b1);          wait_done("madd_acc", 1'b0);
`ifdef MULT_SEQ_MADD_EN
    check("madd_final", {bus.hi, bus.lo}, 64'h00000000_000000FF);
`else
    check("madd_final", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
